// File: rtl/mp_arith_pkg.sv
// Shared types and constants for the multi-precision arithmetic datapath.
package mp_arith_pkg;

    localparam int unsigned LIMB_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [LIMB_W-1:0] limb_t;

endpackage : mp_arith_pkg

// File: rtl/adder_16bit.sv
// 16-bit carry-lookahead limb adder: 4-bit groups with group generate/propagate
// and a block-level lookahead across the four groups.
module adder_16bit
    import mp_arith_pkg::*;
(
    input  logic [15:0] iA,
    input  logic [15:0] iB,
    input  logic        iC,
    output logic [15:0] oSum,
    output logic        oC,
    output logic [3:0]  oG,
    output logic [3:0]  oP,
    output logic [15:0] oC_array
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] ci;
    logic [15:0] co;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  bc;

    // Bit generate/propagate, group lookahead, then per-bit carries inside each group.
    always_comb begin
        p  = iA ^ iB;
        g  = iA & iB;
        gg = '0;
        gp = '0;
        bc = '0;
        ci = '0;
        co = '0;
        bc[0] = iC;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            bc[k+1] = gg[k] | (gp[k] & bc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                ci[4*k+j] = (j == 0) ? bc[k] : co[4*k+j-1];
                co[4*k+j] = g[4*k+j] | (p[4*k+j] & ci[4*k+j]);
            end
        end
    end

    assign oSum     = p ^ ci;
    assign oC       = bc[4];
    assign oG       = gg;
    assign oP       = gp;
    assign oC_array = co;

endmodule : adder_16bit

// File: rtl/mp_addsub_seq.sv
// Sequential multi-precision add/subtract: streams LS-first 16-bit limbs,
// chains carry/borrow through a register, one output register stage.
module mp_addsub_seq #(
    parameter int unsigned LIMB_W = 16,
    parameter int unsigned LIMBS  = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic [LIMB_W-1:0] iA,
    input  logic [LIMB_W-1:0] iB,
    input  logic              iSub,
    output logic              oValid,
    input  logic              iReady,
    output logic [LIMB_W-1:0] oSum,
    output logic              oLast,
    output logic              oC,
    output logic              oZero
);

    import mp_arith_pkg::*;

    localparam int unsigned IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              zacc_q, zacc_d;
    logic              mode_q, mode_d;
    logic              valid_q, valid_d;
    limb_t             sum_q, sum_d;
    logic              last_q, last_d;
    logic              c_q, c_d;
    logic              zero_q, zero_d;

    logic              accept_c;
    logic              take_c;
    logic              first_c;
    logic              last_limb_c;
    logic              mode_c;
    logic              cin;
    logic              zacc_c;
    logic              sum_zero_c;
    limb_t             bop;
    limb_t             sum;
    logic              cout;
    logic [3:0]        g_unused;
    logic [3:0]        p_unused;
    logic [15:0]       carries_unused;

    assign oReady   = !iRst && (!valid_q || iReady);
    assign accept_c = iValid && oReady;
    assign take_c   = valid_q && iReady;

    // Limb 0 takes its mode and carry-in from iSub; later limbs use the registers.
    assign first_c     = (state_q == IDLE);
    assign last_limb_c = (idx_q == IDX_W'(LIMBS - 1));
    assign mode_c      = first_c ? iSub : mode_q;
    assign cin         = first_c ? iSub : carry_q;
    assign bop         = mode_c ? ~limb_t'(iB) : limb_t'(iB);
    assign zacc_c      = first_c ? 1'b1 : zacc_q;
    assign sum_zero_c  = (sum == '0);

    adder_16bit u_adder (
        .iA       (limb_t'(iA)),
        .iB       (bop),
        .iC       (cin),
        .oSum     (sum),
        .oC       (cout),
        .oG       (g_unused),
        .oP       (p_unused),
        .oC_array (carries_unused)
    );

    // Next-state for the limb FSM, chained carry/zero accumulators and output register.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        zacc_d  = zacc_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        last_d  = last_q;
        c_d     = c_q;
        zero_d  = zero_q;

        if (accept_c) begin
            valid_d = 1'b1;
            sum_d   = sum;
            last_d  = last_limb_c;
            if (first_c) begin
                mode_d = iSub;
            end
            if (last_limb_c) begin
                state_d = IDLE;
                idx_d   = '0;
                carry_d = 1'b0;
                zacc_d  = 1'b1;
                c_d     = mode_c ? ~cout : cout;
                zero_d  = zacc_c & sum_zero_c;
            end else begin
                state_d = RUN;
                idx_d   = idx_q + IDX_W'(1);
                carry_d = cout;
                zacc_d  = zacc_c & sum_zero_c;
                c_d     = 1'b0;
                zero_d  = 1'b0;
            end
        end else if (take_c) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b1;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            c_q     <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
        end
    end

    assign oValid = valid_q;
    assign oSum   = LIMB_W'(sum_q);
    assign oLast  = last_q;
    assign oC     = c_q;
    assign oZero  = zero_q;

endmodule : mp_addsub_seq

// File: doc/mp_addsub_seq.md
# mp_addsub_seq

Sequential multi-precision adder/subtractor. It streams two wide operands as 16-bit limbs, least-significant limb first, and produces A+B or A−B one limb per cycle. The carry or borrow is chained between limbs in a register, so each cycle needs only one 16-bit carry-lookahead add. It sits downstream of the operand buffers in the multi-precision datapath and is the subtract/accumulate counterpart of the combinational 16-bit limb adder.

## Interface
Parameters:
- LIMB_W, 16, limb width in bits; only 16 is supported.
- LIMBS, 4, limbs per operation; the operand width is LIMBS*LIMB_W. Must be ≥ 2.

Ports:
- iClk  input  1  clock.
- iRst  input  1  reset; synchronous, active-high.
- iValid  input  1  input limb valid.
- oReady  output  1  block can accept an input limb.
- iA  input  LIMB_W  limb of operand A.
- iB  input  LIMB_W  limb of operand B.
- iSub  input  1  operation select (1 = A−B, 0 = A+B); sampled only on limb 0.
- oValid  output  1  output limb valid.
- iReady  input  1  downstream accepts the output limb.
- oSum  output  LIMB_W  result limb.
- oLast  output  1  marks the final limb of an operation.
- oC  output  1  final carry-out on add, or final borrow on sub; meaningful only when oLast=1.
- oZero  output  1  whole result is zero; meaningful only when oLast=1.

## Operation
- An input beat is accepted when iValid && oReady. An output beat is taken when oValid && iReady.
- oReady = !iRst && (!oValid || iReady). This gives one output register stage with pass-through on the ready path.
- FSM states:
  - IDLE: the next accepted beat is limb 0.
  - RUN: limbs 1..LIMBS-1.
- FSM transitions:
  - IDLE→RUN on accepting limb 0.
  - RUN→IDLE on accepting limb LIMBS-1.
  - A counter idx (0..LIMBS-1) tracks the limb index and wraps to 0 with the RUN→IDLE transition.
- On limb 0:
  - mode_q ← iSub.
  - The effective carry-in is iSub: 1 for subtract (two's-complement +1), 0 for add.
- On later limbs the carry-in is the carry_q register.
- Per limb:
  - Bop = mode ? ~iB : iB.
  - {cout, sum} = iA + Bop + cin, a 17-bit result.
  - carry_q ← cout.
  - oSum ← sum.
- Zero tracking:
  - zacc ← (idx==0 ? 1 : zacc) & (sum==0).
  - oZero ← zacc & (sum==0) on the last limb.
- On the last limb:
  - oLast ← 1.
  - oC ← mode ? ~cout : cout, so subtract reports 1 when A<B unsigned.
  - carry_q and zacc return to their idle values.
- Back-to-back operations are permitted with no bubble. Limb 0 of the next operation never uses the previous carry_q.
- Reset at any time:
  - FSM → IDLE, idx → 0, carry_q → 0, zacc → 1, mode_q → 0.
  - All outputs take their reset values.
  - A partially streamed operation is discarded, and the next accepted beat is treated as limb 0.

## Timing
- Latency is 1 cycle: a limb accepted at edge n appears on oSum with oValid=1 after edge n.
- Throughput is 1 limb per cycle when iReady is held high.
- Backpressure: while oValid && !iReady, oSum, oLast, oC and oZero hold stable and no input is accepted.
- Simultaneous output-taken and input-accepted in the same cycle: the register reloads, and there is no bubble.
- Reset values:
  - oValid=0, oSum=0, oLast=0, oC=0, oZero=0.
  - oReady=0 while iRst=1, and 1 on the first cycle after reset.
- oC and oZero are 0 on non-last beats.
- The critical path is one 16-bit carry-lookahead add plus the carry-in mux. There is no inter-limb combinational chain.

## Structure
- Shared package mp_arith_pkg holds:
  - LIMB_W localparam.
  - State enum {IDLE, RUN}.
  - The limb type (logic [LIMB_W-1:0]).
- One sub-module: adder_16bit as the limb datapath. Connections:
  - iA → iA.
  - Bop → iB.
  - cin → iC.
  - oSum → sum.
  - oC → cout.
  - The G/P/oC_array outputs are left unconnected.
- The FSM, counter, carry and zero accumulators, and output register live in the top module.

## Test plan
All vectors use LIMBS=4; limbs are listed LS-first.
- Sub, A={0000,0001,0000,0000}, B={0001,0000,0000,0000} → oSum beats {FFFF,0000,0000,0000}; oLast on beat 4; oC=0, oZero=0.
- Sub, A=0, B={0001,0,0,0} → all beats FFFF; oC=1 (borrow), oZero=0.
- Add, A={FFFF,FFFF,FFFF,FFFF}, B={0001,0,0,0} → all beats 0000; oC=1, oZero=1.
- Sub, A=B={1234,5678,9ABC,DEF0} → all zero; oC=0, oZero=1.
- Backpressure: drop iReady for 3 cycles after beat 2 → oSum and oValid held stable, oReady=0, no limb lost or duplicated; the remaining beats are correct.
- Reset after 2 limbs of a sub, then an add of {0001,0,0,0}+{0001,0,0,0} → result {0002,0,0,0} with oC=0, showing that mode and carry were re-initialised.
